aim_controller: RTL and testbench

AIM_CONTROLLER -- requirements
Module: aim_controller

---
 rtl/aim_pkg.sv | 43 ++++
 rtl/sweep_tick.sv | 35 +++
 rtl/aim_controller.sv | 124 ++++++++++++
 tb/tb_aim_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aim_pkg.sv
// Shared types and defaults for the aim controller and its sweep helpers.
package aim_pkg;

    localparam int VALUE_W          = 7;
    localparam int ANGLE_MAX_DEF    = 90;
    localparam int STRENGTH_MAX_DEF = 100;
    localparam int TICK_DIV_DEF     = 2500000;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        AIM_ANGLE    = 3'd1,
        AIM_STRENGTH = 3'd2,
        FIRE         = 3'd3,
        FLIGHT       = 3'd4
    } aim_state_e;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic               dir_up;
    } sweep_t;

    // One ping-pong step; direction flips as soon as an end point is reached.
    function automatic sweep_t sweep_step(input logic [VALUE_W-1:0] value,
                                          input logic               dir_up,
                                          input logic [VALUE_W-1:0] max_val);
        sweep_t r;
        if (max_val == '0)
            r.value = '0;
        else if (dir_up ? (value < max_val) : (value == '0))
            r.value = value + VALUE_W'(1);
        else
            r.value = value - VALUE_W'(1);

        if (r.value >= max_val)
            r.dir_up = 1'b0;
        else if (r.value == '0)
            r.dir_up = 1'b1;
        else
            r.dir_up = dir_up;
        return r;
    endfunction

endpackage

// File: rtl/sweep_tick.sv
// Free-running divider that pulses tick every TICK_DIV enabled cycles;
// dropping enable for one cycle restarts the count from zero.
module sweep_tick
    import aim_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = '0;
        if (enable && (count_q != LAST))
            count_d = count_q + CNT_W'(1);
    end

    assign tick = enable && (count_q == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/aim_controller.sv
// Two-stage aiming FSM: sweep angle, then strength, then fire and wait for
// the projectile to land.
module aim_controller
    import aim_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int ANGLE_MAX    = ANGLE_MAX_DEF,
    parameter int STRENGTH_MAX = STRENGTH_MAX_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               btn,
    input  logic               shot_done,
    output logic [VALUE_W-1:0] angle,
    output logic [VALUE_W-1:0] strength,
    output logic               fire,
    output logic [2:0]         phase,
    output logic               busy
);

    localparam logic [VALUE_W-1:0] ANGLE_MAX_V    = VALUE_W'(ANGLE_MAX);
    localparam logic [VALUE_W-1:0] STRENGTH_MAX_V = VALUE_W'(STRENGTH_MAX);

    aim_state_e         state_q, state_d;
    logic [VALUE_W-1:0] angle_q, angle_d;
    logic [VALUE_W-1:0] strength_q, strength_d;
    logic               dir_up_q, dir_up_d;
    logic               fire_q, fire_d;
    logic               busy_q, busy_d;
    logic               in_aim;
    logic               tick_en;
    logic               tick;
    sweep_t             step;

    assign in_aim = (state_q == AIM_ANGLE) || (state_q == AIM_STRENGTH);

    // btn always moves an aim state on, so masking it here zeroes the count at every transition.
    assign tick_en = in_aim && !btn;

    sweep_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_sweep_tick (
        .clk    (clk),
        .resetn (resetn),
        .enable (tick_en),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        angle_d    = angle_q;
        strength_d = strength_q;
        dir_up_d   = dir_up_q;
        step       = (state_q == AIM_ANGLE)
                   ? sweep_step(angle_q, dir_up_q, ANGLE_MAX_V)
                   : sweep_step(strength_q, dir_up_q, STRENGTH_MAX_V);

        case (state_q)
            IDLE: begin
                if (btn) begin
                    state_d  = AIM_ANGLE;
                    angle_d  = '0;
                    dir_up_d = 1'b1;
                end
            end
            AIM_ANGLE: begin
                if (btn) begin
                    state_d    = AIM_STRENGTH;
                    strength_d = '0;
                    dir_up_d   = 1'b1;
                end else if (tick) begin
                    angle_d  = step.value;
                    dir_up_d = step.dir_up;
                end
            end
            AIM_STRENGTH: begin
                if (btn) begin
                    state_d = FIRE;
                end else if (tick) begin
                    strength_d = step.value;
                    dir_up_d   = step.dir_up;
                end
            end
            FIRE: begin
                state_d = FLIGHT;
            end
            FLIGHT: begin
                if (shot_done)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fire_d = (state_d == FIRE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            angle_q    <= '0;
            strength_q <= '0;
            dir_up_q   <= 1'b1;
            fire_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            angle_q    <= angle_d;
            strength_q <= strength_d;
            dir_up_q   <= dir_up_d;
            fire_q     <= fire_d;
            busy_q     <= busy_d;
        end
    end

    assign angle    = angle_q;
    assign strength = strength_q;
    assign fire     = fire_q;
    assign phase    = state_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_aim_controller.sv
// Bench for aim_controller: directed vector table, reset corner case and a
// randomized run against a cycle-count based reference model.
module tb_aim_controller;

    localparam int TICK_DIV     = 4;
    localparam int ANGLE_MAX    = 3;
    localparam int STRENGTH_MAX = 2;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_AIM_A = 3'd1;
    localparam logic [2:0] PH_AIM_S = 3'd2;
    localparam logic [2:0] PH_FIRE  = 3'd3;
    localparam logic [2:0] PH_FLITE = 3'd4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       btn = 1'b0;
    logic       shot_done = 1'b0;
    logic [6:0] angle;
    logic [6:0] strength;
    logic       fire;
    logic [2:0] phase;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    aim_controller #(
        .TICK_DIV     (TICK_DIV),
        .ANGLE_MAX    (ANGLE_MAX),
        .STRENGTH_MAX (STRENGTH_MAX)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .btn       (btn),
        .shot_done (shot_done),
        .angle     (angle),
        .strength  (strength),
        .fire      (fire),
        .phase     (phase),
        .busy      (busy)
    );

    // One pulse cycle of inputs, then `idle` quiet cycles, then the expected outputs.
    typedef struct {
        logic       btn;
        logic       shot_done;
        int         idle;
        logic [2:0] phase;
        logic [6:0] angle;
        logic [6:0] strength;
        logic       fire;
        logic       busy;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic b, input logic s, input int idle,
                                input logic [2:0] ph, input int an, input int st,
                                input logic fi, input logic bu);
        vec_t v;
        v.btn = b; v.shot_done = s; v.idle = idle; v.phase = ph;
        v.angle = 7'(an); v.strength = 7'(st); v.fire = fi; v.busy = bu;
        return v;
    endfunction

    // Reference model: aim values come from the number of elapsed ticks folded onto a triangle wave.
    int m_phase;
    int m_cyc;
    int m_angle;
    int m_strength;

    function automatic int pingpong(input int ticks, input int mx);
        int p;
        if (mx == 0) return 0;
        p = ticks % (2 * mx);
        return (p <= mx) ? p : (2 * mx - p);
    endfunction

    task automatic modelReset();
        m_phase = 0; m_cyc = 0; m_angle = 0; m_strength = 0;
    endtask

    task automatic modelStep(input logic b, input logic s);
        case (m_phase)
            0: if (b) begin m_phase = 1; m_cyc = 0; m_angle = 0; end
            1: if (b) begin
                   m_angle = pingpong(m_cyc / TICK_DIV, ANGLE_MAX);
                   m_strength = 0; m_phase = 2; m_cyc = 0;
               end else m_cyc++;
            2: if (b) begin
                   m_strength = pingpong(m_cyc / TICK_DIV, STRENGTH_MAX);
                   m_phase = 3;
               end else m_cyc++;
            3: m_phase = 4;
            default: if (s) m_phase = 0;
        endcase
    endtask

    task automatic applyStimulus(input logic b, input logic s);
        @(negedge clk);
        btn = b;
        shot_done = s;
        @(posedge clk);
        #1;
        btn = 1'b0;
        shot_done = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] ph, input logic [6:0] an,
                               input logic [6:0] st, input logic chk_st,
                               input logic fi, input logic bu);
        logic ok;
        tests_run++;
        ok = (phase === ph) && (angle === an) && (!chk_st || (strength === st))
             && (fire === fi) && (busy === bu);
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL %s: got phase=%0d angle=%0d strength=%0d fire=%b busy=%b, want phase=%0d angle=%0d strength=%0d fire=%b busy=%b",
                     name, phase, angle, strength, fire, busy, ph, an, st, fi, bu);
        end
    endtask

    task automatic checkModel(input string name);
        int ea;
        int es;
        ea = (m_phase == 1) ? pingpong(m_cyc / TICK_DIV, ANGLE_MAX) : m_angle;
        es = (m_phase == 2) ? pingpong(m_cyc / TICK_DIV, STRENGTH_MAX) : m_strength;
        checkOutput(name, 3'(m_phase), 7'(ea), 7'(es), m_phase != 1,
                    m_phase == 3, m_phase != 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        tests_failed++;
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic b;
        logic s;

        vecs[0]  = mk(1, 0, 0, PH_AIM_A, 0, 0, 0, 1);
        vecs[1]  = mk(0, 1, 2, PH_AIM_A, 0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, PH_AIM_A, 1, 0, 0, 1);
        vecs[3]  = mk(0, 0, 7, PH_AIM_A, 3, 0, 0, 1);
        vecs[4]  = mk(0, 0, 3, PH_AIM_A, 2, 0, 0, 1);
        vecs[5]  = mk(0, 0, 7, PH_AIM_A, 0, 0, 0, 1);
        vecs[6]  = mk(0, 0, 3, PH_AIM_A, 1, 0, 0, 1);
        vecs[7]  = mk(1, 0, 0, PH_AIM_S, 1, 0, 0, 1);
        vecs[8]  = mk(0, 0, 3, PH_AIM_S, 1, 1, 0, 1);
        vecs[9]  = mk(0, 0, 3, PH_AIM_S, 1, 2, 0, 1);
        vecs[10] = mk(0, 0, 2, PH_AIM_S, 1, 2, 0, 1);
        vecs[11] = mk(1, 0, 0, PH_FIRE,  1, 2, 1, 1);
        vecs[12] = mk(0, 0, 0, PH_FLITE, 1, 2, 0, 1);
        vecs[13] = mk(1, 0, 2, PH_FLITE, 1, 2, 0, 1);
        vecs[14] = mk(0, 1, 0, PH_IDLE,  1, 2, 0, 0);
        vecs[15] = mk(0, 1, 1, PH_IDLE,  1, 2, 0, 0);

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", PH_IDLE, 0, 0, 1, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].btn, vecs[i].shot_done);
            for (int j = 0; j < vecs[i].idle; j++)
                applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].phase, vecs[i].angle,
                        vecs[i].strength, 1'b1, vecs[i].fire, vecs[i].busy);
        end

        // Reset in the middle of the strength sweep abandons the shot.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0);
        checkOutput("mid_strength", PH_AIM_S, 0, 1, 1, 0, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("async_reset", PH_IDLE, 0, 0, 1, 0, 0);
        btn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("held_reset", PH_IDLE, 0, 0, 1, 0, 0);
        btn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("post_reset%0d", i), PH_IDLE, 0, 0, 1, 0, 0);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_aim", PH_AIM_A, 0, 0, 1, 0, 1);

        // Randomized run against the reference model.
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3000; i++) begin
            checkModel($sformatf("rand%0d", i));
            if (m_phase == 1 || m_phase == 2)
                b = ($urandom_range(0, 39) == 0);
            else
                b = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 5) == 0);
            applyStimulus(b, s);
            modelStep(b, s);
        end
        checkModel("rand_final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
